arp_sequencer: RTL and testbench

Arpeggiator scheduler that sits between the synth control register block and the per-voice envelope/oscillator datapath. When arpeggio is disabled it passes the host key gates straight through with one cycle of registering. When enabled it gates exactly one held voice at a time and steps round-robin through the held keys. Each step lasts ARP_TIME milliseconds and ends with a short silent gap, which forces the envelope to retrigger.

---
 rtl/synth_ctrl_pkg.sv | 40 ++++
 rtl/arp_sequencer_if.sv | 24 ++
 rtl/tick_prescaler.sv | 29 ++
 rtl/arp_sequencer.sv | 140 ++++++++++++++
 tb/tb_arp_sequencer.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/synth_ctrl_pkg.sv
// Shared types and helpers for the synth control / arpeggiator slice.
// Holds the arp state enum, voice count, tick default and round-robin scan.
package synth_ctrl_pkg;

  localparam int NUM_VOICES   = 4;
  localparam int TICK_DIV_DEF = 50000;

  typedef enum logic [1:0] {
    BYPASS,
    IDLE,
    NOTE_ON,
    GAP
  } arp_state_t;

  // First held key after idx, wrapping; idx itself is checked last
  // so a lone held key repeats.
  function automatic logic [1:0] next_held(
    input logic [1:0]            idx,
    input logic [NUM_VOICES-1:0] keys
  );
    logic [1:0] r;
    logic [1:0] c;
    r = idx;
    for (int i = NUM_VOICES; i >= 1; i--) begin
      c = idx + 2'(i);
      if (keys[c]) r = c;
    end
    return r;
  endfunction

  function automatic logic [NUM_VOICES-1:0] onehot(
    input logic [1:0] i
  );
    logic [NUM_VOICES-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/arp_sequencer_if.sv
// Control/gate bundle between host regs, arpeggiator and voice datapath.
// master: drives ARP_EN/ARP_TIME/KEY_IN; slave: drives gates and status.
interface arp_sequencer_if;
  import synth_ctrl_pkg::*;

  logic                  ARP_EN;
  logic [15:0]           ARP_TIME;
  logic [NUM_VOICES-1:0] KEY_IN;
  logic [NUM_VOICES-1:0] KEY_OUT;
  logic [1:0]            STEP_IDX;
  logic                  STEP_STROBE;
  logic                  ARP_ACTIVE;

  modport master (
    output ARP_EN, ARP_TIME, KEY_IN,
    input  KEY_OUT, STEP_IDX, STEP_STROBE, ARP_ACTIVE
  );

  modport slave (
    input  ARP_EN, ARP_TIME, KEY_IN,
    output KEY_OUT, STEP_IDX, STEP_STROBE, ARP_ACTIVE
  );

endinterface

// File: rtl/tick_prescaler.sv
// Millisecond timebase: counts 0..TICK_DIV-1, tick high on the last count.
// Ports: CLK, RESET (sync, high), clear (restart count at 0), tick.
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/arp_sequencer.sv
// Arpeggiator: key gate bypass or round-robin single-voice stepping.
// Ports: CLK, RESET (sync, high), bus (slave side of arp_sequencer_if).
module arp_sequencer
  import synth_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int GAP_TICKS = 2
) (
  input  logic           CLK,
  input  logic           RESET,
  arp_sequencer_if.slave bus
);

  arp_state_t  state;
  logic [1:0]  idx;
  logic [15:0] tcnt;

  logic        tick;
  logic        clear;
  logic        start;
  logic [1:0]  start_idx;
  logic        any_key;
  logic        drop;
  logic        note_done;
  logic        gap_done;
  logic [15:0] t_eff;
  logic [15:0] note_len;
  logic [16:0] tnext;
  logic [1:0]  first_idx;
  logic [1:0]  rr_idx;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .CLK  (CLK),
    .RESET(RESET),
    .clear(clear),
    .tick (tick)
  );

  assign any_key   = |bus.KEY_IN;
  assign drop      = ~bus.KEY_IN[idx];
  assign t_eff     = (bus.ARP_TIME > 16'(GAP_TICKS))
                   ? bus.ARP_TIME : 16'(GAP_TICKS + 1);
  assign note_len  = t_eff - 16'(GAP_TICKS);
  assign tnext     = {1'b0, tcnt} + 17'd1;
  // Compare on each tick so a shortened ARP_TIME ends the note at
  // the next tick instead of restarting the step.
  assign note_done = tick && (tnext >= {1'b0, note_len});
  assign gap_done  = tick && (tnext >= 17'(GAP_TICKS));
  // Scanning from voice 3 yields the lowest held key.
  assign first_idx = next_held(2'd3, bus.KEY_IN);
  assign rr_idx    = next_held(idx, bus.KEY_IN);

  // Phase entries restart the prescaler so every phase is whole ticks.
  always_comb begin
    start     = 1'b0;
    clear     = 1'b0;
    start_idx = first_idx;
    if (bus.ARP_EN) begin
      case (state)
        BYPASS, IDLE: begin
          start = any_key;
          clear = any_key;
        end
        NOTE_ON: begin
          clear = drop || note_done;
        end
        GAP: begin
          start     = gap_done && any_key;
          clear     = gap_done && any_key;
          start_idx = rr_idx;
        end
        default: begin
          start = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state           <= BYPASS;
      idx             <= '0;
      tcnt            <= '0;
      bus.KEY_OUT     <= '0;
      bus.STEP_IDX    <= '0;
      bus.STEP_STROBE <= 1'b0;
      bus.ARP_ACTIVE  <= 1'b0;
    end else begin
      bus.STEP_STROBE <= 1'b0;
      if (start) begin
        state           <= NOTE_ON;
        idx             <= start_idx;
        tcnt            <= '0;
        bus.KEY_OUT     <= onehot(start_idx);
        bus.STEP_IDX    <= start_idx;
        bus.STEP_STROBE <= 1'b1;
        bus.ARP_ACTIVE  <= 1'b1;
      end else if (!bus.ARP_EN) begin
        // Leaving arp mode spends one cycle silent before passthrough.
        state          <= BYPASS;
        bus.ARP_ACTIVE <= 1'b0;
        bus.KEY_OUT    <= (state == BYPASS) ? bus.KEY_IN : '0;
      end else begin
        case (state)
          BYPASS: begin
            state       <= IDLE;
            bus.KEY_OUT <= '0;
          end
          IDLE: begin
            state <= IDLE;
          end
          NOTE_ON: begin
            if (drop || note_done) begin
              state       <= GAP;
              tcnt        <= '0;
              bus.KEY_OUT <= '0;
            end else if (tick) begin
              tcnt <= tnext[15:0];
            end
          end
          GAP: begin
            if (gap_done) begin
              state          <= IDLE;
              tcnt           <= '0;
              bus.ARP_ACTIVE <= 1'b0;
            end else if (tick) begin
              tcnt <= tnext[15:0];
            end
          end
          default: begin
            state <= BYPASS;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_arp_sequencer.sv
// Scoreboard bench for arp_sequencer with TICK_DIV=4, GAP_TICKS=1.
// Stimulus queues per-cycle expectations; a negedge monitor checks them.
module tb_arp_sequencer;

  typedef struct {
    int         cyc;
    logic [3:0] ko;
    logic [1:0] idx;
    logic       strb;
    logic       act;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc_cnt;
  int   errors;
  int   checks;
  exp_t sb[$];

  arp_sequencer_if bus();

  arp_sequencer #(
    .TICK_DIV (4),
    .GAP_TICKS(1)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt = cyc_cnt + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = sb.pop_front();
      checks = checks + 1;
      if (e.cyc != cyc_cnt) begin
        errors = errors + 1;
        $display("FAIL stale_exp: cycle %0d, required cycle %0d",
                 cyc_cnt, e.cyc);
      end else if (bus.KEY_OUT !== e.ko || bus.STEP_IDX !== e.idx ||
                   bus.STEP_STROBE !== e.strb ||
                   bus.ARP_ACTIVE !== e.act) begin
        errors = errors + 1;
        $display({"FAIL out@cyc%0d: got ko=%b idx=%0d strb=%b act=%b,",
                  " required ko=%b idx=%0d strb=%b act=%b"},
                 cyc_cnt, bus.KEY_OUT, bus.STEP_IDX, bus.STEP_STROBE,
                 bus.ARP_ACTIVE, e.ko, e.idx, e.strb, e.act);
      end
    end
  end

  // Hold inputs for n cycles, expecting the given outputs each cycle;
  // strobe is expected on the first of those cycles only.
  task automatic run(input int n, input logic [3:0] ko,
                     input logic [1:0] idx, input logic strb,
                     input logic act);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.cyc  = cyc_cnt + 1;
      e.ko   = ko;
      e.idx  = idx;
      e.strb = (i == 0) ? strb : 1'b0;
      e.act  = act;
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic en, input logic [15:0] t,
                       input logic [3:0] keys);
    bus.ARP_EN   = en;
    bus.ARP_TIME = t;
    bus.KEY_IN   = keys;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    drive(1'b0, 16'd0, 4'b0101);
    @(posedge clk);
    #1;
    // reset state
    run(2, 4'b0000, 2'd0, 1'b0, 1'b0);
    // bypass: one-cycle registered passthrough
    rst = 1'b0;
    run(3, 4'b0101, 2'd0, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 4'b1010);
    run(2, 4'b1010, 2'd0, 1'b0, 1'b0);
    // round robin over 1011, T=3: 8 on, 4 gap
    drive(1'b1, 16'd3, 4'b1011);
    run(8, 4'b0001, 2'd0, 1'b1, 1'b1);
    run(4, 4'b0000, 2'd0, 1'b0, 1'b1);
    run(8, 4'b0010, 2'd1, 1'b1, 1'b1);
    run(4, 4'b0000, 2'd1, 1'b0, 1'b1);
    run(8, 4'b1000, 2'd3, 1'b1, 1'b1);
    run(4, 4'b0000, 2'd3, 1'b0, 1'b1);
    run(8, 4'b0001, 2'd0, 1'b1, 1'b1);
    run(4, 4'b0000, 2'd0, 1'b0, 1'b1);
    // early release of voice 1
    run(2, 4'b0010, 2'd1, 1'b1, 1'b1);
    drive(1'b1, 16'd3, 4'b1001);
    run(4, 4'b0000, 2'd1, 1'b0, 1'b1);
    run(2, 4'b1000, 2'd3, 1'b1, 1'b1);
    // all keys released: gap then idle
    drive(1'b1, 16'd3, 4'b0000);
    run(4, 4'b0000, 2'd3, 1'b0, 1'b1);
    run(3, 4'b0000, 2'd3, 1'b0, 1'b0);
    // disable: one silent cycle, then passthrough
    drive(1'b0, 16'd3, 4'b0011);
    run(1, 4'b0000, 2'd3, 1'b0, 1'b0);
    run(2, 4'b0011, 2'd3, 1'b0, 1'b0);
    // single key, ARP_TIME=0 clamps T to 2: 4 on, 4 gap
    drive(1'b1, 16'd0, 4'b0100);
    for (int r = 0; r < 3; r++) begin
      run(4, 4'b0100, 2'd2, 1'b1, 1'b1);
      run(4, 4'b0000, 2'd2, 1'b0, 1'b1);
    end
    // ARP_TIME shrink after 2 ticks ends note at next tick
    drive(1'b1, 16'd5, 4'b0100);
    run(10, 4'b0100, 2'd2, 1'b1, 1'b1);
    drive(1'b1, 16'd2, 4'b0100);
    run(2, 4'b0100, 2'd2, 1'b0, 1'b1);
    run(4, 4'b0000, 2'd2, 1'b0, 1'b1);
    // reset mid-note, then restart at lowest held key
    run(3, 4'b0100, 2'd2, 1'b1, 1'b1);
    rst = 1'b1;
    drive(1'b1, 16'd2, 4'b0110);
    run(1, 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    run(4, 4'b0010, 2'd1, 1'b1, 1'b1);
    run(4, 4'b0000, 2'd1, 1'b0, 1'b1);
    run(2, 4'b0100, 2'd2, 1'b1, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
